// File: rtl/fifo_flow_monitor_if.sv
// fifo_flow_monitor_if: strobe/flag bundle between the QoS control side and
// the FIFO flow monitor.
//   master : drives init, hi_thr_in, lo_thr_in, push, pop; observes the flags.
//   slave  : the monitor; observes strobes/thresholds, drives occupancy,
//            empty, full, pause_fifos, continue_fifos, drop, thr_error.
interface fifo_flow_monitor_if #(
  parameter int NUM_FIFOS = 4,
  parameter int CNT_W     = 5
);
  logic                         init;
  logic [CNT_W-1:0]             hi_thr_in;
  logic [CNT_W-1:0]             lo_thr_in;
  logic [NUM_FIFOS-1:0]         push;
  logic [NUM_FIFOS-1:0]         pop;
  logic [NUM_FIFOS*CNT_W-1:0]   occupancy;
  logic [NUM_FIFOS-1:0]         empty;
  logic [NUM_FIFOS-1:0]         full;
  logic [NUM_FIFOS-1:0]         pause_fifos;
  logic [NUM_FIFOS-1:0]         continue_fifos;
  logic [NUM_FIFOS-1:0]         drop;
  logic                         thr_error;

  modport master (
    output init, hi_thr_in, lo_thr_in, push, pop,
    input  occupancy, empty, full, pause_fifos, continue_fifos, drop, thr_error
  );

  modport slave (
    input  init, hi_thr_in, lo_thr_in, push, pop,
    output occupancy, empty, full, pause_fifos, continue_fifos, drop, thr_error
  );
endinterface

// File: rtl/fifo_flow_monitor.sv
// fifo_flow_monitor: occupancy tracking and pause/continue hysteresis for
// NUM_FIFOS per-class FIFOs.
//   CLK   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fifo_flow_monitor_if.slave (strobes, thresholds, flags)
// One lane per FIFO holds the count and RUN/PAUSED state; the shared
// threshold registers load while init is high and reject lo >= hi or hi > DEPTH.

module fifo_flow_monitor_lane #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [CNT_W-1:0] i_hi_thr,
  input  logic [CNT_W-1:0] i_lo_thr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_paused,
  output logic             o_continue,
  output logic             o_drop
);
  typedef enum logic {RUN, PAUSED} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_continue;
  logic             r_drop;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CNT_W-1:0] w_nxt;

  // Blocking is judged on the current count, so push+pop on a full FIFO
  // drops the push and on an empty FIFO drops the pop.
  assign w_push_ok = i_push && (r_cnt != CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop  && (r_cnt != '0);
  assign w_nxt     = r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_continue <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_cnt      <= w_nxt;
      r_drop     <= (i_push && !w_push_ok) || (i_pop && !w_pop_ok);
      r_continue <= 1'b0;
      // Hysteresis compares the next count so the flag lines up with occupancy.
      case (r_state)
        RUN:    if (w_nxt >= i_hi_thr) r_state <= PAUSED;
        PAUSED: if (w_nxt <= i_lo_thr) begin
                  r_state    <= RUN;
                  r_continue <= 1'b1;
                end
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_cnt      = r_cnt;
  assign o_paused   = (r_state == PAUSED);
  assign o_continue = r_continue;
  assign o_drop     = r_drop;
endmodule

module fifo_flow_monitor #(
  parameter int NUM_FIFOS  = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 5,
  parameter int HI_DEFAULT = 12,
  parameter int LO_DEFAULT = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  fifo_flow_monitor_if.slave   bus
);
  logic [CNT_W-1:0]                  r_hi_thr;
  logic [CNT_W-1:0]                  r_lo_thr;
  logic                              r_thr_error;
  logic [NUM_FIFOS-1:0][CNT_W-1:0]   w_cnt;
  logic [NUM_FIFOS-1:0]              w_paused;
  logic [NUM_FIFOS-1:0]              w_continue;
  logic [NUM_FIFOS-1:0]              w_drop;
  logic [NUM_FIFOS-1:0]              w_empty;
  logic [NUM_FIFOS-1:0]              w_full;
  logic                              w_thr_ok;

  assign w_thr_ok = (bus.lo_thr_in < bus.hi_thr_in) &&
                    (bus.hi_thr_in <= CNT_W'(DEPTH));

  // Lanes see the registered thresholds, so a load applies from the next edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_hi_thr    <= CNT_W'(HI_DEFAULT);
      r_lo_thr    <= CNT_W'(LO_DEFAULT);
      r_thr_error <= 1'b0;
    end else begin
      r_thr_error <= 1'b0;
      if (bus.init) begin
        if (w_thr_ok) begin
          r_hi_thr <= bus.hi_thr_in;
          r_lo_thr <= bus.lo_thr_in;
        end else begin
          r_thr_error <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_lane
    fifo_flow_monitor_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane (
      .CLK        (CLK),
      .reset      (reset),
      .i_push     (bus.push[g]),
      .i_pop      (bus.pop[g]),
      .i_hi_thr   (r_hi_thr),
      .i_lo_thr   (r_lo_thr),
      .o_cnt      (w_cnt[g]),
      .o_paused   (w_paused[g]),
      .o_continue (w_continue[g]),
      .o_drop     (w_drop[g])
    );
  end

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      w_empty[i] = (w_cnt[i] == '0);
      w_full[i]  = (w_cnt[i] == CNT_W'(DEPTH));
    end
  end

  assign bus.occupancy      = w_cnt;
  assign bus.empty          = w_empty;
  assign bus.full           = w_full;
  assign bus.pause_fifos    = w_paused;
  assign bus.continue_fifos = w_continue;
  assign bus.drop           = w_drop;
  assign bus.thr_error      = r_thr_error;
endmodule

// File: tb/tb_fifo_flow_monitor.sv
module tb_fifo_flow_monitor;
  localparam int N = 4;
  localparam int W = 5;
  localparam int D = 16;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  fifo_flow_monitor_if #(.NUM_FIFOS(N), .CNT_W(W)) bus ();

  fifo_flow_monitor #(.NUM_FIFOS(N), .DEPTH(D), .CNT_W(W),
                      .HI_DEFAULT(12), .LO_DEFAULT(4)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integer counts and a paused flag per FIFO.
  int m_cnt[N];
  bit m_paused[N];
  bit m_cont[N];
  bit m_drop[N];
  int m_hi, m_lo;
  bit m_terr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_paused[i] = 0; m_cont[i] = 0; m_drop[i] = 0;
    end
    m_hi = 12; m_lo = 4; m_terr = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] p, input logic [N-1:0] q,
                            input logic in, input int h, input int l);
    for (int i = 0; i < N; i++) begin
      bit pa, po;
      int nx;
      pa = p[i] && (m_cnt[i] < D);
      po = q[i] && (m_cnt[i] > 0);
      m_drop[i] = (p[i] && !pa) || (q[i] && !po);
      nx = m_cnt[i] + int'(pa) - int'(po);
      m_cont[i] = 0;
      if (!m_paused[i] && nx >= m_hi) m_paused[i] = 1;
      else if (m_paused[i] && nx <= m_lo) begin
        m_paused[i] = 0; m_cont[i] = 1;
      end
      m_cnt[i] = nx;
    end
    m_terr = 0;
    if (in) begin
      if (l < h && h <= D) begin m_hi = h; m_lo = l; end
      else m_terr = 1;
    end
  endtask

  // One clock: drive at negedge, update model at posedge, leave DUT settled #1 later.
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] q,
                      input logic in = 1'b0, input logic [W-1:0] h = '0,
                      input logic [W-1:0] l = '0);
    @(negedge CLK);
    bus.push = p; bus.pop = q; bus.init = in; bus.hi_thr_in = h; bus.lo_thr_in = l;
    @(posedge CLK);
    model_edge(p, q, in, int'(h), int'(l));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    bus.push = '0; bus.pop = '0; bus.init = 1'b0;
    bus.hi_thr_in = '0; bus.lo_thr_in = '0;
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [W-1:0] occ(input int i);
    logic [N*W-1:0] v;
    v = bus.occupancy;
    return v[i*W +: W];
  endfunction

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (bus.empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %h exp F", bus.empty); end
    n_checks++; if (bus.full !== 4'h0) begin n_fail++; $display("FAIL reset_full got %h exp 0", bus.full); end
    n_checks++; if (bus.pause_fifos !== 4'h0) begin n_fail++; $display("FAIL reset_pause got %h exp 0", bus.pause_fifos); end
    n_checks++; if (bus.occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got %h exp 0", bus.occupancy); end
    n_checks++; if ({bus.continue_fifos, bus.drop, bus.thr_error} !== '0) begin
      n_fail++; $display("FAIL reset_pulses got %h/%h/%b exp 0", bus.continue_fifos, bus.drop, bus.thr_error); end
  endtask

  task automatic test_hysteresis();
    for (int k = 1; k <= 12; k++) begin
      step(4'b0001, 4'b0000);
      if (k == 11) begin
        n_checks++; if (bus.pause_fifos !== 4'b0000) begin n_fail++; $display("FAIL hyst_pause_at11 got %b exp 0000", bus.pause_fifos); end
      end
    end
    n_checks++; if (bus.pause_fifos !== 4'b0001) begin n_fail++; $display("FAIL hyst_pause_at12 got %b exp 0001", bus.pause_fifos); end
    n_checks++; if (occ(0) !== 5'd12) begin n_fail++; $display("FAIL hyst_occ12 got %0d exp 12", occ(0)); end
    for (int k = 1; k <= 8; k++) begin
      step(4'b0000, 4'b0001);
      if (k == 7) begin
        n_checks++; if ({bus.pause_fifos, bus.continue_fifos} !== 8'b0001_0000) begin
          n_fail++; $display("FAIL hyst_at5 got p=%b c=%b exp p=0001 c=0000", bus.pause_fifos, bus.continue_fifos); end
      end
    end
    n_checks++; if ({bus.pause_fifos, bus.continue_fifos} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL hyst_continue got p=%b c=%b exp p=0000 c=0001", bus.pause_fifos, bus.continue_fifos); end
    n_checks++; if (occ(0) !== 5'd4) begin n_fail++; $display("FAIL hyst_occ4 got %0d exp 4", occ(0)); end
    step(4'b0000, 4'b0000);
    n_checks++; if (bus.continue_fifos !== 4'b0000) begin n_fail++; $display("FAIL hyst_continue_width got %b exp 0000", bus.continue_fifos); end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 16; k++) step(4'b0100, 4'b0000);
    n_checks++; if (bus.full[2] !== 1'b1 || occ(2) !== 5'd16) begin
      n_fail++; $display("FAIL full_reach got full=%b cnt=%0d exp 1/16", bus.full, occ(2)); end
    n_checks++; if (bus.drop !== 4'b0000) begin n_fail++; $display("FAIL full_nodrop got %b exp 0000", bus.drop); end
    step(4'b0100, 4'b0000);
    n_checks++; if (bus.drop !== 4'b0100 || occ(2) !== 5'd16) begin
      n_fail++; $display("FAIL full_overflow got drop=%b cnt=%0d exp 0100/16", bus.drop, occ(2)); end
    step(4'b0100, 4'b0100);
    n_checks++; if (bus.drop !== 4'b0100 || occ(2) !== 5'd15 || bus.full[2] !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop got drop=%b cnt=%0d full=%b exp 0100/15/0", bus.drop, occ(2), bus.full[2]); end
  endtask

  task automatic test_empty();
    step(4'b0010, 4'b0010);
    n_checks++; if (bus.drop !== 4'b0010 || occ(1) !== 5'd1) begin
      n_fail++; $display("FAIL empty_pushpop got drop=%b cnt=%0d exp 0010/1", bus.drop, occ(1)); end
    step(4'b0000, 4'b1000);
    n_checks++; if (bus.drop !== 4'b1000 || occ(3) !== 5'd0 || bus.empty[3] !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop got drop=%b cnt=%0d exp 1000/0", bus.drop, occ(3)); end
  endtask

  task automatic test_thresholds();
    apply_reset();
    for (int k = 0; k < 10; k++) step(4'b0001, 4'b0000);
    n_checks++; if (bus.pause_fifos !== 4'b0000) begin n_fail++; $display("FAIL thr_run10 got %b exp 0000", bus.pause_fifos); end
    step(4'b0000, 4'b0000, 1'b1, 5'd8, 5'd2);
    n_checks++; if (bus.pause_fifos !== 4'b0000 || bus.thr_error !== 1'b0) begin
      n_fail++; $display("FAIL thr_load_edge got p=%b err=%b exp 0000/0", bus.pause_fifos, bus.thr_error); end
    step(4'b0000, 4'b0000);
    n_checks++; if (bus.pause_fifos !== 4'b0001) begin n_fail++; $display("FAIL thr_apply got %b exp 0001", bus.pause_fifos); end
    step(4'b0000, 4'b0000, 1'b1, 5'd3, 5'd5);
    n_checks++; if (bus.thr_error !== 1'b1) begin n_fail++; $display("FAIL thr_reject got %b exp 1", bus.thr_error); end
    step(4'b0000, 4'b0000, 1'b1, 5'd17, 5'd1);
    n_checks++; if (bus.thr_error !== 1'b1) begin n_fail++; $display("FAIL thr_reject_depth got %b exp 1", bus.thr_error); end
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 4'b0000);
      if (k == 1) begin
        n_checks++; if (bus.thr_error !== 1'b0) begin n_fail++; $display("FAIL thr_err_pulse got %b exp 0", bus.thr_error); end
      end
      if (k == 7) begin
        n_checks++; if (bus.pause_fifos !== 4'b0001) begin n_fail++; $display("FAIL thr_keep7 got %b exp 0001", bus.pause_fifos); end
      end
    end
    n_checks++; if (bus.pause_fifos !== 4'b0011) begin n_fail++; $display("FAIL thr_keep8 got %b exp 0011", bus.pause_fifos); end
  endtask

  task automatic test_reset_midburst();
    for (int k = 0; k < 13; k++) step(4'b1111, 4'b0000);
    n_checks++; if (bus.pause_fifos !== 4'b1111) begin n_fail++; $display("FAIL mid_preburst got %b exp 1111", bus.pause_fifos); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.empty !== 4'hF || bus.occupancy !== '0 || bus.pause_fifos !== 4'h0 || bus.full !== 4'h0) begin
      n_fail++; $display("FAIL mid_async got e=%h occ=%h p=%h f=%h exp F/0/0/0", bus.empty, bus.occupancy, bus.pause_fifos, bus.full); end
    @(negedge CLK);
    bus.push = '0; bus.init = 1'b0;
    reset = 1'b1;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      step(4'b0001, 4'b0000);
      if (k == 11) begin
        n_checks++; if (bus.pause_fifos !== 4'b0000) begin n_fail++; $display("FAIL mid_thr11 got %b exp 0000", bus.pause_fifos); end
      end
    end
    n_checks++; if (bus.pause_fifos !== 4'b0001) begin n_fail++; $display("FAIL mid_thr12 got %b exp 0001", bus.pause_fifos); end
  endtask

  task automatic test_random();
    logic [N*W-1:0] e_occ;
    logic [N-1:0]   e_emp, e_full, e_p, e_c, e_d;
    logic [N-1:0]   p, q;
    apply_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      // Bias toward pushes in the first half and pops in the second to sweep levels.
      for (int i = 0; i < N; i++) begin
        p[i] = ($urandom_range(99) < ((cyc % 200) < 100 ? 70 : 30));
        q[i] = ($urandom_range(99) < ((cyc % 200) < 100 ? 30 : 70));
      end
      if ($urandom_range(19) == 0)
        step(p, q, 1'b1, W'($urandom_range(20)), W'($urandom_range(16)));
      else
        step(p, q);
      for (int i = 0; i < N; i++) begin
        e_occ[i*W +: W] = W'(m_cnt[i]);
        e_emp[i] = (m_cnt[i] == 0);
        e_full[i] = (m_cnt[i] == D);
        e_p[i] = m_paused[i];
        e_c[i] = m_cont[i];
        e_d[i] = m_drop[i];
      end
      n_checks++; if (bus.occupancy !== e_occ) begin n_fail++; $display("FAIL rnd_occ cyc %0d got %h exp %h", cyc, bus.occupancy, e_occ); end
      n_checks++; if (bus.empty !== e_emp || bus.full !== e_full) begin
        n_fail++; $display("FAIL rnd_flags cyc %0d got e=%b f=%b exp e=%b f=%b", cyc, bus.empty, bus.full, e_emp, e_full); end
      n_checks++; if (bus.pause_fifos !== e_p) begin n_fail++; $display("FAIL rnd_pause cyc %0d got %b exp %b", cyc, bus.pause_fifos, e_p); end
      n_checks++; if (bus.continue_fifos !== e_c) begin n_fail++; $display("FAIL rnd_continue cyc %0d got %b exp %b", cyc, bus.continue_fifos, e_c); end
      n_checks++; if (bus.drop !== e_d) begin n_fail++; $display("FAIL rnd_drop cyc %0d got %b exp %b", cyc, bus.drop, e_d); end
      n_checks++; if (bus.thr_error !== m_terr) begin n_fail++; $display("FAIL rnd_thr_error cyc %0d got %b exp %b", cyc, bus.thr_error, m_terr); end
      n_checks++; if ((bus.pause_fifos & bus.continue_fifos) !== '0) begin
        n_fail++; $display("FAIL rnd_exclusive cyc %0d got p=%b c=%b exp no overlap", cyc, bus.pause_fifos, bus.continue_fifos); end
    end
  endtask

  initial begin
    bus.push = '0; bus.pop = '0; bus.init = 1'b0;
    bus.hi_thr_in = '0; bus.lo_thr_in = '0;
    model_reset();
    test_reset();
    test_hysteresis();
    test_full();
    test_empty();
    test_thresholds();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_flow_monitor.md
# fifo_flow_monitor

- Occupancy and flow-control front end for the four per-class FIFOs of the QoS module.
- Tracks each FIFO's fill level from its push/pop strobes and drives the `empty`, `full`, `pause_fifos` and `continue_fifos` vectors that the QoS control FSM consumes.
- Applies per-FIFO hysteresis between programmable high and low thresholds.
- Loads new thresholds while the FSM reports its init phase.

## Interface
- NUM_FIFOS, 4, number of monitored FIFOs (FSM vectors are 4 bits wide).
- DEPTH, 16, entries per FIFO.
- CNT_W, 5, counter width; must hold 0..DEPTH.
- HI_DEFAULT, 12, high (pause) threshold after reset.
- LO_DEFAULT, 4, low (continue) threshold after reset.

- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  threshold load enable; driven from the FSM `init` output.
- hi_thr_in  in  CNT_W  candidate high threshold.
- lo_thr_in  in  CNT_W  candidate low threshold.
- push  in  NUM_FIFOS  per-FIFO write strobe, one entry per cycle.
- pop  in  NUM_FIFOS  per-FIFO read strobe, one entry per cycle.
- occupancy  out  NUM_FIFOS*CNT_W  packed counts; FIFO i is at bits [i*CNT_W +: CNT_W].
- empty  out  NUM_FIFOS  count == 0.
- full  out  NUM_FIFOS  count == DEPTH.
- pause_fifos  out  NUM_FIFOS  level output; 1 while FIFO i is in PAUSED.
- continue_fifos  out  NUM_FIFOS  one-cycle pulse when FIFO i leaves PAUSED.
- drop  out  NUM_FIFOS  one-cycle pulse; a push on a full FIFO or a pop on an empty FIFO was discarded.
- thr_error  out  1  one-cycle pulse; a threshold load was rejected.

## Operation
**Counter update**, per FIFO, evaluated in this order:
- A push is accepted if the FIFO is not full.
- A pop is accepted if the FIFO is not empty.
- Next count = count + accepted push − accepted pop.
- Push and pop together with neither blocked: count unchanged.
- Push and pop together while full: pop accepted, push dropped, count − 1, `drop` pulses.
- Push and pop together while empty: push accepted, pop dropped, count + 1, `drop` pulses.

**Hysteresis FSM**, per FIFO, states RUN and PAUSED. Both transitions use the next count (not the current count) and the current thresholds.
- RUN → PAUSED when next count ≥ hi_thr.
- PAUSED → RUN when next count ≤ lo_thr; `continue_fifos[i]` pulses on that same edge.
- Otherwise the state holds.
- `pause_fifos[i]` = (state == PAUSED).

**Thresholds** (registers hi_thr and lo_thr):
- Sampled on every edge where `init`=1.
- Accepted only if lo_thr_in < hi_thr_in ≤ DEPTH.
- On rejection the registers keep their old values and `thr_error` pulses for one cycle.
- A newly accepted threshold takes effect on the following edge's evaluation; a FIFO's state may change then without any push or pop.

**Derived flags**:
- `empty`, `full` and `occupancy` are combinational decodes of the registered counts.
- All other outputs are registered.

## Timing
- Reset (asynchronous assert, synchronous release): all counts 0, all FIFOs in RUN, hi_thr=HI_DEFAULT, lo_thr=LO_DEFAULT.
- Output values in reset: `empty`=4'hF, `full`=0, `pause_fifos`=0, `continue_fifos`=0, `drop`=0, `thr_error`=0.
- Latency: one cycle from a strobe to all outputs. A push at edge N that makes count reach hi_thr shows `pause_fifos[i]`=1 and the new `occupancy` together after edge N.
- `continue_fifos` is never high in the same cycle as `pause_fifos` for the same FIFO.
- Equal thresholds never occur because loads with lo_thr_in ≥ hi_thr_in are rejected.
- A reset asserted mid-operation clears state immediately, regardless of CLK. Pending strobes are lost.
- Counters saturate by construction: they never wrap past DEPTH or below 0.

## Test plan
- Reset with all strobes idle → `empty`=4'hF, `full`=0, `pause_fifos`=0, every `occupancy` field 0.
- 12 pushes to FIFO0 → `pause_fifos`=4'b0001 in the cycle where count=12. Then 8 pops → on the edge where count becomes 4, `pause_fifos`=0 and `continue_fifos`=4'b0001 for exactly one cycle.
- 17 pushes to FIFO2 → `full[2]`=1 and count=16; the 17th push gives `drop`=4'b0100 and no count change. Then push and pop together → count=15 and `drop` pulses.
- FIFO1 empty, push and pop together → count=1 and `drop`=4'b0010. Pop on an empty FIFO3 → `drop`=4'b1000.
- `init`=1 with hi=8, lo=2 while FIFO0 holds 10 in RUN → FIFO0 enters PAUSED next edge. `init`=1 with hi=3, lo=5 → `thr_error` pulses and hi stays 8.
- Reset pulsed mid-burst on all FIFOs → outputs return to reset values immediately, thresholds return to 12 and 4.
